clock_gate_controller: RTL and testbench
========================================

# clock_gate_controller

Per-domain idle-detect clock gating controller. It drives the enable inputs of NUM_DOMAINS downstream clock gating cells, one per domain. Each gating cell contains a two-flop enable synchroniser and a latch-based gate. The controller turns a domain's clock off after a programmable number of consecutive idle cycles. It restores the clock through a wake_req/domain_ready handshake that accounts for the gating cell's enable-synchroniser latency.

## Interface
- NUM_DOMAINS, 4: number of independently gated clock domains.
- IDLE_CNT_W, 8: width of the idle counter and of idle_threshold.
- WAKE_LAT, 2: enable-synchroniser depth of the gating cell, in clk_in cycles.

- clk_in  input  1  free-running (ungated) clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- test_mode  input  1  scan/test override; forces every clock on.
- idle_threshold  input  IDLE_CNT_W  consecutive idle cycles before gating; 0 disables gating for all domains.
- domain_busy  input  NUM_DOMAINS  per-domain activity indication, sampled each cycle.
- wake_req  input  NUM_DOMAINS  per-domain request to run; held high by the requester until domain_ready is seen high.
- gate_en  output  NUM_DOMAINS  enable to the domain's gating cell; 1 = clock running.
- domain_ready  output  NUM_DOMAINS  1 = the gated clock is guaranteed toggling in that domain.
- gated_status  output  NUM_DOMAINS  1 = domain is in GATED state.

## Operation
- One independent FSM per domain. States: RUN, GATED, WAKE. Each domain also has an idle counter (IDLE_CNT_W bits) and a wake counter (wide enough for WAKE_LAT+1).
- Idle cycle: domain_busy[i]=0 and wake_req[i]=0.
- RUN:
  - gate_en=1, domain_ready=1, gated_status=0.
  - A non-idle cycle clears the idle counter to 0.
  - On an idle cycle, if idle_threshold≠0 and idle counter+1 ≥ idle_threshold, go to GATED and clear the counter. Otherwise increment the counter, saturating at all-ones.
- GATED:
  - gate_en=0, domain_ready=0, gated_status=1.
  - domain_busy is ignored in this state.
  - wake_req[i]=1: go to WAKE and load the wake counter with WAKE_LAT.
- WAKE:
  - gate_en=1, domain_ready=0, gated_status=0.
  - The wake counter decrements each cycle. When it is 0, go to RUN.
  - Deasserting wake_req does not abort the wake sequence.
- idle_threshold is compared live, not latched. If it is lowered below the current count, the domain gates on the next idle cycle. Changing it from nonzero to 0 stops all further gating; domains already GATED stay GATED until woken.
- test_mode=1:
  - Combinationally forces gate_en=1 and domain_ready=1 for all domains, and gated_status=0.
  - Synchronously forces every FSM to RUN and clears both counters.
  - After test_mode falls, counting restarts from 0.
- All outputs are registered state decodes, except the combinational test_mode override. gate_en must be glitch-free when test_mode is stable.

## Timing
- Reset values: all FSMs RUN, gate_en=all ones, domain_ready=all ones, gated_status=0, all counters 0. Clocks are on out of reset.
- Gating latency: with threshold N≥1 and domain_busy falling before edge T (idle from edge T), gate_en[i] falls after edge T+N-1. That is, N idle samples cause gating.
- Wake latency: wake_req sampled high at edge T while in GATED:
  - gate_en rises after edge T.
  - domain_ready rises after edge T+WAKE_LAT+1.
  - With the default WAKE_LAT=2, domain_ready rises 3 cycles after the request.
- Simultaneous events:
  - wake_req=1 on the threshold cycle counts as non-idle, so the domain does not gate.
  - domain_busy=1 on the threshold cycle likewise prevents gating.
  - Domains never interact; several may gate or wake on the same edge.
- A wake_req held high in RUN keeps the domain ungated indefinitely.
- rst mid-WAKE or mid-GATED returns the domain to RUN with gate_en=1 on the next edge.

## Test plan
- Reset and idle-gate: rst 2 cycles, idle_threshold=4, all domain_busy=0. Required: gate_en=4'b1111 out of reset; gate_en falls to 0 and gated_status to 4'b1111 exactly 4 cycles after rst release.
- Busy interruption: threshold=4, domain 0 idle 3 cycles, busy 1 cycle, then idle. Required: domain 0 gates only 4 cycles after the busy pulse; other domains gate on schedule.
- Wake handshake: domain 2 GATED, wake_req[2] pulsed at edge T and held. Required: gate_en[2]=1 after T; domain_ready[2]=0 until T+3, then 1. Drop wake_req, stay idle 4 cycles: domain 2 re-gates.
- Collisions: wake_req rising on the threshold cycle leaves the domain in RUN. Threshold changed 4→0 mid-count means no gating ever occurs. Threshold lowered 10→2 after 5 idle cycles means the domain gates on the next edge.
- test_mode: assert with 2 domains GATED and 1 in WAKE. Required: gate_en and domain_ready read all ones the same cycle. Deassert: full threshold count is required before any regating.
- Reset mid-operation: rst during WAKE on domain 1. Required: domain 1 in RUN with gate_en=1 and domain_ready=1 after the next edge, counters 0.

Source files
------------

// File: rtl/clock_gate_controller.sv
// Per-domain idle-detect clock gating controller.
// Gates each domain after idle_threshold idle cycles, wakes via wake_req handshake.
module clock_gate_controller #(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_CNT_W  = 8,
  parameter int WAKE_LAT    = 2
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   test_mode,
  input  logic [IDLE_CNT_W-1:0]  idle_threshold,
  input  logic [NUM_DOMAINS-1:0] domain_busy,
  input  logic [NUM_DOMAINS-1:0] wake_req,
  output logic [NUM_DOMAINS-1:0] gate_en,
  output logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] gated_status
);

  localparam int WC_W = $clog2(WAKE_LAT + 2);
  localparam int CW   = IDLE_CNT_W + 1;

  localparam logic [WC_W-1:0]       WAKE_INIT = WC_W'(WAKE_LAT);
  localparam logic [IDLE_CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0]         ONE_X     = CW'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } state_t;

  state_t                state_q [NUM_DOMAINS];
  state_t                state_d [NUM_DOMAINS];
  logic [IDLE_CNT_W-1:0] idle_q  [NUM_DOMAINS];
  logic [IDLE_CNT_W-1:0] idle_d  [NUM_DOMAINS];
  logic [WC_W-1:0]       wake_q  [NUM_DOMAINS];
  logic [WC_W-1:0]       wake_d  [NUM_DOMAINS];

  logic [NUM_DOMAINS-1:0] idle_v;
  logic [NUM_DOMAINS-1:0] run_d, run_q;
  logic [NUM_DOMAINS-1:0] gated_d, gated_q;
  logic                   thr_on;

  assign idle_v = ~domain_busy & ~wake_req;
  assign thr_on = (idle_threshold != '0);

  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      wake_d[i]  = wake_q[i];
      unique case (state_q[i])
        RUN: begin
          if (!idle_v[i]) begin
            idle_d[i] = '0;
          end else if (thr_on &&
                       (CW'(idle_q[i]) + ONE_X >=
                        CW'(idle_threshold))) begin
            state_d[i] = GATED;
            idle_d[i]  = '0;
          end else if (idle_q[i] != CNT_MAX) begin
            idle_d[i] = idle_q[i] + 1'b1;
          end
        end
        GATED: begin
          if (wake_req[i]) begin
            state_d[i] = WAKE;
            wake_d[i]  = WAKE_INIT;
          end
        end
        WAKE: begin
          if (wake_q[i] == '0) begin
            state_d[i] = RUN;
          end else begin
            wake_d[i] = wake_q[i] - 1'b1;
          end
        end
        default: state_d[i] = RUN;
      endcase
      if (test_mode) begin
        state_d[i] = RUN;
        idle_d[i]  = '0;
        wake_d[i]  = '0;
      end
      run_d[i]   = (state_d[i] == RUN);
      gated_d[i] = (state_d[i] == GATED);
    end
  end

  // Output decodes are flopped so gate_en never glitches on state changes.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_q[i] <= RUN;
        idle_q[i]  <= '0;
        wake_q[i]  <= '0;
      end
      run_q   <= '1;
      gated_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_q[i] <= state_d[i];
        idle_q[i]  <= idle_d[i];
        wake_q[i]  <= wake_d[i];
      end
      run_q   <= run_d;
      gated_q <= gated_d;
    end
  end

  assign gate_en      = ~gated_q | {NUM_DOMAINS{test_mode}};
  assign domain_ready = run_q | {NUM_DOMAINS{test_mode}};
  assign gated_status = gated_q & ~{NUM_DOMAINS{test_mode}};

endmodule

// File: tb/tb_clock_gate_controller.sv
// Directed self-checking bench for clock_gate_controller.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_clock_gate_controller;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       test_mode;
  logic [7:0] idle_threshold;
  logic [3:0] domain_busy;
  logic [3:0] wake_req;
  logic [3:0] gate_en;
  logic [3:0] domain_ready;
  logic [3:0] gated_status;

  int n_cmp = 0;
  int n_err = 0;

  clock_gate_controller #(
    .NUM_DOMAINS(4),
    .IDLE_CNT_W (8),
    .WAKE_LAT   (2)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .test_mode     (test_mode),
    .idle_threshold(idle_threshold),
    .domain_busy   (domain_busy),
    .wake_req      (wake_req),
    .gate_en       (gate_en),
    .domain_ready  (domain_ready),
    .gated_status  (gated_status)
  );

  always #5 clk_in = ~clk_in;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] g,
                      input logic [3:0] r, input logic [3:0] s);
    chk({tag, ".gate_en"}, gate_en, g);
    chk({tag, ".ready"}, domain_ready, r);
    chk({tag, ".gated"}, gated_status, s);
  endtask

  initial begin
    rst = 1'b1;
    test_mode = 1'b0;
    idle_threshold = 8'd4;
    domain_busy = 4'b0000;
    wake_req = 4'b0000;

    // reset and idle gating
    step(2);
    chk3("reset", 4'b1111, 4'b1111, 4'b0000);
    rst = 1'b0;
    step(3);
    chk3("idle3", 4'b1111, 4'b1111, 4'b0000);
    step();
    chk3("idle4", 4'b0000, 4'b0000, 4'b1111);

    // busy interruption on domain 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(3);
    domain_busy = 4'b0001;
    step();
    chk("busy.edge4", gate_en, 4'b0001);
    domain_busy = 4'b0000;
    step(3);
    chk("busy.plus3", gate_en, 4'b0001);
    step();
    chk3("busy.plus4", 4'b0000, 4'b0000, 4'b1111);

    // wake handshake on domain 2
    wake_req = 4'b0100;
    step();
    chk3("wake.t0", 4'b0100, 4'b0000, 4'b1011);
    step();
    chk("wake.t1", domain_ready, 4'b0000);
    step();
    chk("wake.t2", domain_ready, 4'b0000);
    step();
    chk3("wake.t3", 4'b0100, 4'b0100, 4'b1011);
    wake_req = 4'b0000;
    step(3);
    chk("regate.3", gate_en, 4'b0100);
    step();
    chk("regate.4", gate_en, 4'b0000);

    // wake_req on threshold cycle, then held in RUN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(3);
    wake_req = 4'b0001;
    step();
    chk3("coll.wake", 4'b0001, 4'b0001, 4'b1110);
    step(5);
    chk("coll.held", gate_en, 4'b0001);
    wake_req = 4'b0000;

    // threshold 4 -> 0 mid count
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(2);
    idle_threshold = 8'd0;
    step(10);
    chk3("thr0", 4'b1111, 4'b1111, 4'b0000);

    // threshold 10 -> 2 after 5 idle cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_threshold = 8'd10;
    step(5);
    chk("thr10.5", gate_en, 4'b1111);
    idle_threshold = 8'd2;
    step();
    chk("thr2.next", gate_en, 4'b0000);
    idle_threshold = 8'd4;

    // build mix: d3 RUN, d1 WAKE, d0/d2 GATED
    wake_req = 4'b1000;
    step(4);
    chk("mix.d3run", domain_ready, 4'b1000);
    wake_req = 4'b1010;
    step();
    chk3("mix", 4'b1010, 4'b1000, 4'b0101);

    // test_mode override is combinational
    test_mode = 1'b1;
    #1;
    chk3("tm.comb", 4'b1111, 4'b1111, 4'b0000);
    wake_req = 4'b0000;
    step(3);
    chk3("tm.held", 4'b1111, 4'b1111, 4'b0000);
    test_mode = 1'b0;
    #1;
    chk3("tm.off", 4'b1111, 4'b1111, 4'b0000);
    step(3);
    chk("tm.cnt3", gate_en, 4'b1111);
    step();
    chk("tm.cnt4", gate_en, 4'b0000);

    // reset during WAKE on domain 1
    wake_req = 4'b0010;
    step(2);
    chk3("rw.wake", 4'b0010, 4'b0000, 4'b1101);
    rst = 1'b1;
    wake_req = 4'b0000;
    step();
    chk3("rw.rst", 4'b1111, 4'b1111, 4'b0000);
    rst = 1'b0;
    step(3);
    chk("rw.cnt3", gate_en, 4'b1111);
    step();
    chk("rw.cnt4", gate_en, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
